// File: rtl/fetch_stage_if.sv
// Hazard-control, instruction-memory and IF/ID signal bundle for fetch_stage.
interface fetch_stage_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 16
);
   logic               pc_write_en;
   logic               if_id_write_en;
   logic               if_id_clean;
   logic               doJump;
   logic [PC_W-1:0]    jump_target;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] if_id_instr;
   logic [PC_W-1:0]    if_id_pc_plus1;
   logic               if_id_valid;
   logic               run;
   logic               halted;

   modport master (
      output pc_write_en, if_id_write_en, if_id_clean, doJump, jump_target, imem_rdata,
      input  imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid, run, halted
   );

   modport slave (
      input  pc_write_en, if_id_write_en, if_id_clean, doJump, jump_target, imem_rdata,
      output imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid, run, halted
   );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC, IF/ID register and HLT drain/halt FSM driven by the hazard unit.
// Optional perf counters enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter int                  PC_W         = 16,
   parameter int                  INSTR_W      = 16,
   parameter logic [PC_W-1:0]     RESET_PC     = 16'h0000,
   parameter logic [INSTR_W-1:0]  NOP_INSTR    = 16'h0000,
   parameter logic [3:0]          HLT_OPCODE   = 4'hF,
   parameter int                  DRAIN_CYCLES = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   fetch_stage_if.slave   bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]    perf_stall_cnt,
   output logic [15:0]    perf_flush_cnt,
   output logic [15:0]    perf_fetch_cnt
`endif
);
   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PC_W-1:0]    pc_q, pc_d, pc_plus1;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pp1_q, pp1_d;
   logic               valid_q, valid_d;
   logic               run_q, halted_q;
   logic               hlt_fetch, flush, fetch_load;

   assign pc_plus1  = pc_q + 1'b1;
   assign flush     = bus.if_id_clean || bus.doJump;
   assign hlt_fetch = (state_q == S_RUN) && (bus.imem_rdata[INSTR_W-1 -: 4] == HLT_OPCODE);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pp1_d      = pp1_q;
      valid_d    = valid_q;
      fetch_load = 1'b0;
      // HALTED freezes everything until reset
      if (state_q != S_HALTED) begin
         if (bus.doJump)
            pc_d = bus.jump_target;
         else if (state_q == S_RUN && bus.pc_write_en && !hlt_fetch)
            pc_d = pc_plus1;

         if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end else if (bus.if_id_write_en) begin
            if (state_q == S_RUN) begin
               instr_d    = bus.imem_rdata;
               pp1_d      = pc_plus1;
               valid_d    = 1'b1;
               fetch_load = 1'b1;
            end else begin
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end
         end

         case (state_q)
            S_RUN: begin
               if (hlt_fetch && bus.if_id_write_en && !flush) begin
                  state_d = S_DRAIN;
                  cnt_d   = CNT_W'(DRAIN_CYCLES);
               end
            end
            S_DRAIN: begin
               // a jump means the HLT sat in a squashed shadow
               if (bus.doJump) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
               end else if (bus.if_id_write_en) begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == CNT_W'(1)) state_d = S_HALTED;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_RUN;
         cnt_q    <= '0;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pp1_q    <= '0;
         valid_q  <= 1'b0;
         run_q    <= 1'b1;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pp1_q    <= pp1_d;
         valid_q  <= valid_d;
         run_q    <= (state_d != S_HALTED);
         halted_q <= (state_d == S_HALTED);
      end
   end

   assign bus.imem_addr      = pc_q;
   assign bus.if_id_instr    = instr_q;
   assign bus.if_id_pc_plus1 = pp1_q;
   assign bus.if_id_valid    = valid_q;
   assign bus.run            = run_q;
   assign bus.halted         = halted_q;

`ifdef FETCH_PERF_CNT_EN
   logic stall_ev, flush_ev;
   assign stall_ev = !bus.pc_write_en && (state_q == S_RUN) && !bus.doJump;
   assign flush_ev = flush && (state_q != S_HALTED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
         perf_fetch_cnt <= '0;
      end else begin
         if (stall_ev   && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
         if (flush_ev   && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
         if (fetch_load && perf_fetch_cnt != 16'hFFFF) perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_stage_if bus();
   logic [15:0] mem [256];
   assign bus.imem_rdata = mem[bus.imem_addr[7:0]];

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_stall_cnt, perf_flush_cnt, perf_fetch_cnt;
   int m_stall, m_flush, m_fetch;
`endif

   fetch_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt),
      .perf_fetch_cnt (perf_fetch_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // model: mode 0 running, 1 draining, 2 halted
   logic [15:0] m_pc, m_instr, m_pp1;
   logic        m_valid;
   int          m_mode, m_left;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc"},    32'(bus.imem_addr),      32'(m_pc));
      chk({tag, ".instr"}, 32'(bus.if_id_instr),    32'(m_instr));
      chk({tag, ".pp1"},   32'(bus.if_id_pc_plus1), 32'(m_pp1));
      chk({tag, ".valid"}, 32'(bus.if_id_valid),    32'(m_valid));
      chk({tag, ".run"},   32'(bus.run),            32'(m_mode != 2));
      chk({tag, ".halt"},  32'(bus.halted),         32'(m_mode == 2));
`ifdef FETCH_PERF_CNT_EN
      chk({tag, ".pstall"}, 32'(perf_stall_cnt), 32'(m_stall));
      chk({tag, ".pflush"}, 32'(perf_flush_cnt), 32'(m_flush));
      chk({tag, ".pfetch"}, 32'(perf_fetch_cnt), 32'(m_fetch));
`endif
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = 16'h0000; m_pp1 = 16'h0000; m_valid = 1'b0;
      m_mode = 0; m_left = 0;
`ifdef FETCH_PERF_CNT_EN
      m_stall = 0; m_flush = 0; m_fetch = 0;
`endif
   endtask

   // fill memory; pct_hlt percent of words carry the HLT opcode
   task automatic fill(input int pct_hlt);
      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'($urandom_range(0, 16'hEFFF));
         if (int'($urandom_range(1, 100)) <= pct_hlt) mem[i] = 16'hF000 | 16'(i);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.pc_write_en = 1'b1; bus.if_id_write_en = 1'b1;
      bus.if_id_clean = 1'b0; bus.doJump = 1'b0; bus.jump_target = 16'h0;
      #1 model_reset();
      chk_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // apply one cycle of controls, advance model and DUT, compare
   task automatic step(input logic pcw, input logic ifw, input logic cln,
                       input logic jmp, input logic [15:0] tgt, input string tag);
      logic [15:0] word, n_pc;
      logic        hlt, flush;
      bus.pc_write_en = pcw; bus.if_id_write_en = ifw;
      bus.if_id_clean = cln; bus.doJump = jmp; bus.jump_target = tgt;
      word  = mem[m_pc[7:0]];
      hlt   = (m_mode == 0) && (word[15:12] == 4'hF);
      flush = cln || jmp;
      if (m_mode != 2) begin
`ifdef FETCH_PERF_CNT_EN
         if (!pcw && m_mode == 0 && !jmp && m_stall < 65535) m_stall++;
         if (flush && m_flush < 65535) m_flush++;
         if (!flush && ifw && m_mode == 0 && m_fetch < 65535) m_fetch++;
`endif
         n_pc = m_pc;
         if (jmp) n_pc = tgt;
         else if (m_mode == 0 && pcw && !hlt) n_pc = m_pc + 16'd1;
         if (flush) begin
            m_instr = 16'h0000; m_valid = 1'b0;
         end else if (ifw && m_mode == 0) begin
            m_instr = word; m_pp1 = m_pc + 16'd1; m_valid = 1'b1;
         end else if (ifw) begin
            m_instr = 16'h0000; m_valid = 1'b0;
         end
         if (m_mode == 0) begin
            if (hlt && ifw && !flush) begin m_mode = 1; m_left = 4; end
         end else if (jmp) begin
            m_mode = 0; m_left = 0;
         end else if (ifw) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
         end
         m_pc = n_pc;
      end
      @(posedge clk);
      #1 chk_all(tag);
   endtask

   initial begin
      int halt_age;
      bus.pc_write_en = 1'b1; bus.if_id_write_en = 1'b1;
      bus.if_id_clean = 1'b0; bus.doJump = 1'b0; bus.jump_target = 16'h0;
      fill(0);
      mem[0] = 16'h1234; mem[1] = 16'h2345;
      model_reset();
      do_reset();

      // basic fetch with latency one
      step(1, 1, 0, 0, 16'h0, "fetch0");
      chk("fetch0.instr_lit", 32'(bus.if_id_instr), 32'h1234);
      chk("fetch0.pp1_lit",   32'(bus.if_id_pc_plus1), 32'h1);
      step(1, 1, 0, 0, 16'h0, "fetch1");
      chk("fetch1.instr_lit", 32'(bus.if_id_instr), 32'h2345);
      chk("fetch1.pc_lit",    32'(bus.imem_addr), 32'h2);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 16'h0, "run");

      // stall three cycles at pc=5
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0, "stall");
      chk("stall.pc_lit", 32'(bus.imem_addr), 32'h5);
`ifdef FETCH_PERF_CNT_EN
      chk("stall.cnt_lit", 32'(perf_stall_cnt), 32'd3);
`endif
      step(1, 1, 0, 0, 16'h0, "release");
      chk("release.pc_lit", 32'(bus.imem_addr), 32'h6);

      // jump overrides pc_write_en=0
      step(0, 1, 0, 1, 16'h0040, "jump");
      chk("jump.pc_lit", 32'(bus.imem_addr), 32'h40);
      step(1, 1, 0, 0, 16'h0, "after_jump");

      // PC wrap
      step(1, 1, 0, 1, 16'hFFFF, "to_ffff");
      step(1, 1, 0, 0, 16'h0, "wrap");
      chk("wrap.pc_lit",  32'(bus.imem_addr), 32'h0);
      chk("wrap.pp1_lit", 32'(bus.if_id_pc_plus1), 32'h0);

      // HLT drain with a stall inside DRAIN
      fill(0);
      mem[8] = 16'hF000;
      do_reset();
      step(1, 1, 0, 1, 16'h0008, "to8");
      step(1, 1, 0, 0, 16'h0, "hlt_latch");
      chk("hlt.pc_hold", 32'(bus.imem_addr), 32'h8);
      step(1, 1, 0, 0, 16'h0, "drain1");
      step(1, 1, 0, 0, 16'h0, "drain2");
      step(0, 0, 0, 0, 16'h0, "drain_stall");
      step(1, 1, 0, 0, 16'h0, "drain3");
      chk("drain3.halted_lit", 32'(bus.halted), 32'h0);
      step(1, 1, 0, 0, 16'h0, "drain4");
      chk("drain4.halted_lit", 32'(bus.halted), 32'h1);
      chk("drain4.run_lit",    32'(bus.run), 32'h0);
      for (int i = 0; i < 4; i++)
         step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), "frozen");

      // jump out of DRAIN, then async reset mid-run
      do_reset();
      step(1, 1, 0, 1, 16'h0008, "to8b");
      step(1, 1, 0, 0, 16'h0, "hlt_latch_b");
      step(1, 1, 0, 0, 16'h0, "drain_b1");
      step(1, 1, 0, 1, 16'h0020, "drain_jump");
      chk("drain_jump.pc_lit", 32'(bus.imem_addr), 32'h20);
      step(1, 1, 0, 0, 16'h0, "resume");
      #2 rst_n = 1'b0;
      #1 chk("async_rst.pc", 32'(bus.imem_addr), 32'h0);
      chk("async_rst.valid", 32'(bus.if_id_valid), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // randomized controls with occasional HLT words
      fill(5);
      halt_age = 0;
      for (int i = 0; i < 500; i++) begin
         step(1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 85),
              1'($urandom_range(0, 99) < 8),  1'($urandom_range(0, 99) < 8),
              16'($urandom), "rand");
         if (m_mode == 2) halt_age++;
         if (halt_age > 3) begin
            halt_age = 0;
            do_reset();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end responder to the pipeline hazard unit. Owns the PC and the IF/ID pipeline register, and obeys the unit's pc_write_en, if_id_write_en, if_id_clean and doJump controls.
- Reads instruction memory combinationally and detects HLT at fetch.
- Runs a halt-drain FSM that lowers run once the pipeline has emptied. run feeds back to the hazard unit's non-dependence logic.

Parameters:
- PC_W, 16, PC and instruction-address width
- INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]
- RESET_PC, 16'h0000, PC value after reset
- NOP_INSTR, 16'h0000, value loaded into IF/ID on flush or bubble
- HLT_OPCODE, 4'hF, opcode that starts a halt
- DRAIN_CYCLES, 4, pipeline advances needed after HLT leaves IF/ID (ID, EX, MEM, WB)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_write_en  in  1  from hazard unit; 0 holds PC
- if_id_write_en  in  1  from hazard unit; 0 holds IF/ID
- if_id_clean  in  1  from hazard unit; flushes IF/ID to NOP
- doJump  in  1  redirect request
- jump_target  in  PC_W  redirect address
- imem_addr  out  PC_W  equal to pc, combinational
- imem_rdata  in  INSTR_W  instruction at imem_addr, same cycle
- if_id_instr  out  INSTR_W  registered instruction
- if_id_pc_plus1  out  PC_W  registered pc+1 of that instruction
- if_id_valid  out  1  1 = if_id_instr is a real fetched instruction
- run  out  1  1 unless HALTED
- halted  out  1  1 in HALTED

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC
  - if_id_instr=NOP_INSTR, if_id_pc_plus1=0, if_id_valid=0
  - state=RUN, drain_cnt=0, run=1, halted=0
- PC update, in priority order each posedge:
  1. doJump: pc<=jump_target. Applies in every state except HALTED and overrides pc_write_en=0.
  2. state==RUN && pc_write_en && !hlt_fetch: pc<=pc+1, modulo 2^PC_W (16'hFFFF -> 16'h0000).
  3. Otherwise hold.
- hlt_fetch = (state==RUN) && (imem_rdata opcode==HLT_OPCODE).
- IF/ID update, in priority order:
  1. if_id_clean or doJump: instr<=NOP_INSTR, valid<=0, pc_plus1 holds.
  2. if_id_write_en && state==RUN: instr<=imem_rdata, pc_plus1<=pc+1, valid<=1.
  3. if_id_write_en && state!=RUN: instr<=NOP_INSTR, valid<=0.
  4. Otherwise hold.
- Fetch latency: instruction at PC p appears in IF/ID one cycle after pc==p with write enables high.
- FSM states RUN, DRAIN, HALTED:
  - RUN -> DRAIN when hlt_fetch && if_id_write_en && !doJump && !if_id_clean. HLT is latched into IF/ID, PC holds, drain_cnt<=DRAIN_CYCLES.
  - RUN with hlt_fetch but write enable low: no transition; retry next cycle.
  - RUN with hlt_fetch and doJump: jump wins, HLT discarded, stay RUN.
  - DRAIN decrements drain_cnt only on cycles with if_id_write_en=1; stalls freeze the count.
  - DRAIN with doJump (HLT was in a squashed shadow): return to RUN, pc<=jump_target, drain_cnt<=0.
  - DRAIN -> HALTED on a decrement from 1 to 0 with no doJump that cycle.
  - HALTED: run=0, halted=1. PC, IF/ID and state are frozen (all inputs ignored) until rst_n=0.
- run and halted are registered, derived directly from state.
- Reset asserted mid-DRAIN or while HALTED returns to RUN at RESET_PC immediately (async).
- Simultaneous stall and jump: the jump is honoured. The hazard unit already masks stall under clear, but this block does not depend on that.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_stall_cnt (16): counts cycles with pc_write_en=0 && state==RUN && !doJump.
  - perf_flush_cnt (16): counts cycles with if_id_clean||doJump.
  - perf_fetch_cnt (16): counts cycles where IF/ID loaded with valid<=1.
- All three reset to 0 and saturate at 16'hFFFF.
- When not defined, these ports and registers do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset release, imem returns 16'h1234 at addr 0 and 16'h2345 at addr 1, enables high -> cycle 1: if_id_instr=1234, pc_plus1=1, valid=1; cycle 2: 2345, pc=2.
- pc_write_en=if_id_write_en=0 for 3 cycles at pc=5 -> pc stays 5 and IF/ID holds. Release -> pc=6 next edge. With perf enabled, perf_stall_cnt=3.
- doJump=1, jump_target=16'h0040, with pc_write_en=0 in the same cycle -> pc=0x40, if_id_instr=NOP, valid=0. Next fetch is from 0x40.
- pc=16'hFFFF with enables high -> pc wraps to 0, if_id_pc_plus1=0.
- HLT (16'hF000) at addr 8 -> PC holds at 8. After 4 advancing cycles plus 1 stall cycle inserted during DRAIN: halted=1, run=0 exactly on the 4th advance, after 5 cycles in DRAIN. All later inputs are ignored.
- HLT enters DRAIN, then doJump to 16'h0020 on the 2nd DRAIN cycle -> state RUN, pc=0x20, halted stays 0. Then assert rst_n=0 mid-run -> pc=RESET_PC asynchronously.
